// File: rtl/brick_state_table.sv
// Alive/dead table for the playfield bricks: serves ball-physics queries (with optional
// kill), keeps the live-brick count, flags level completion and feeds a video read port.
module brick_state_table #(
    parameter int NB_BRIQUES = 320,
    parameter int ADR_W      = 9
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             new_level,
    input  logic             qry_valid,
    input  logic [ADR_W-1:0] qry_adr,
    input  logic             qry_kill,
    output logic             ready,
    output logic             rsp_valid,
    output logic             brique_morte,
    output logic [ADR_W:0]   alive_count,
    output logic             level_clear,
    input  logic [ADR_W-1:0] vid_adr,
    output logic             vid_alive
);

    localparam int               DEPTH    = 2 ** ADR_W;
    localparam logic [ADR_W:0]   NB_CNT   = (ADR_W + 1)'(NB_BRIQUES);
    localparam logic [ADR_W-1:0] LAST_IDX = ADR_W'(NB_BRIQUES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [ADR_W-1:0] idx_q, idx_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             kill_q, kill_d;
    logic             bit_q, bit_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             brique_morte_q, brique_morte_d;
    logic [ADR_W:0]   alive_count_q, alive_count_d;
    logic             level_clear_q, level_clear_d;
    logic             vid_alive_q, vid_alive_d;

    logic             mem_q [DEPTH];
    logic             mem_we;
    logic [ADR_W-1:0] mem_wadr;
    logic             mem_wdata;

    // Addresses past the last brick exist in storage but must never read as alive.
    function automatic logic in_range(input logic [ADR_W-1:0] a);
        return {1'b0, a} < NB_CNT;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d        = state_q;
        idx_d          = idx_q;
        adr_d          = adr_q;
        kill_d         = kill_q;
        bit_d          = bit_q;
        rsp_valid_d    = 1'b0;
        brique_morte_d = brique_morte_q;
        alive_count_d  = alive_count_q;
        mem_we         = 1'b0;
        mem_wadr       = idx_q;
        mem_wdata      = 1'b0;
        level_clear_d  = (alive_count_q == '0) && (state_q != ST_INIT);
        vid_alive_d    = (state_q != ST_INIT) && in_range(vid_adr) && mem_q[vid_adr];

        if (new_level) begin
            // Restart wins over everything, including an in-flight query.
            state_d       = ST_INIT;
            idx_d         = '0;
            alive_count_d = '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    mem_we    = 1'b1;
                    mem_wadr  = idx_q;
                    mem_wdata = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        alive_count_d = NB_CNT;
                        idx_d         = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        idx_d = idx_q + ADR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (qry_valid) begin
                        adr_d   = qry_adr;
                        kill_d  = qry_kill;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    bit_d   = in_range(adr_q) && mem_q[adr_q];
                    state_d = ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_d    = 1'b1;
                    brique_morte_d = ~bit_q;
                    if (kill_q && bit_q) begin
                        mem_we        = 1'b1;
                        mem_wadr      = adr_q;
                        mem_wdata     = 1'b0;
                        alive_count_d = alive_count_q - (ADR_W + 1)'(1);
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= ST_INIT;
            idx_q          <= '0;
            adr_q          <= '0;
            kill_q         <= 1'b0;
            bit_q          <= 1'b0;
            rsp_valid_q    <= 1'b0;
            brique_morte_q <= 1'b0;
            alive_count_q  <= '0;
            level_clear_q  <= 1'b0;
            vid_alive_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            adr_q          <= adr_d;
            kill_q         <= kill_d;
            bit_q          <= bit_d;
            rsp_valid_q    <= rsp_valid_d;
            brique_morte_q <= brique_morte_d;
            alive_count_q  <= alive_count_d;
            level_clear_q  <= level_clear_d;
            vid_alive_q    <= vid_alive_d;
        end
    end

    // NOTE: the array has no reset; INIT sweeps it and every read is gated until INIT ends.
    always_ff @(posedge clk_clk) begin
        if (mem_we) begin
            mem_q[mem_wadr] <= mem_wdata;
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign brique_morte = brique_morte_q;
    assign alive_count  = alive_count_q;
    assign level_clear  = level_clear_q;
    assign vid_alive    = vid_alive_q;

endmodule
